wormhole_switch_allocator: RTL and testbench

//  Per-output-port switch allocator for the 5-port mesh router; replaces the single flat round-robin SA.

---
 rtl/wormhole_switch_allocator.sv | 129 ++++++++++++
 tb/tb_wormhole_switch_allocator.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wormhole_switch_allocator.sv
// Per-outport wormhole switch allocator: round-robin among head flits, holds the outport for
// the winning inport until its tail crosses, with a sticky watchdog for starved locks.
module wormhole_switch_allocator #(
    parameter int unsigned STALL_LIMIT = 256
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  req_valid_i,
    input  logic [24:0] req_outport_i,
    input  logic [4:0]  req_head_i,
    input  logic [4:0]  req_tail_i,
    input  logic [4:0]  downstream_on_i,
    output logic [4:0]  sa_grant_o,
    output logic [24:0] xbar_sel_o,
    output logic [4:0]  outport_busy_o,
    output logic [4:0]  stall_err_o
);

    localparam int CW = $clog2(STALL_LIMIT + 1);

    typedef enum logic {S_IDLE, S_LOCKED} lock_state_e;

    lock_state_e   state_q [5];
    lock_state_e   state_d [5];
    logic [2:0]    owner_q [5];
    logic [2:0]    owner_d [5];
    logic [2:0]    rr_q    [5];
    logic [2:0]    rr_d    [5];
    logic [CW-1:0] cnt_q   [5];
    logic [CW-1:0] cnt_d   [5];
    logic [4:0]    err_q;
    logic [4:0]    err_d;

    logic [4:0]    req_ok;
    logic [4:0]    tgt     [5];
    logic [4:0]    sel     [5];
    logic [2:0]    win     [5];
    logic          found   [5];

    function automatic logic onehot5(input logic [4:0] v);
        return (v != 5'd0) && ((v & (v - 5'd1)) == 5'd0);
    endfunction

    function automatic logic [2:0] wrap5(input logic [3:0] v);
        return (v >= 4'd5) ? 3'(v - 4'd5) : v[2:0];
    endfunction

    always_comb begin
        for (int i = 0; i < 5; i++) begin
            req_ok[i] = req_valid_i[i] && onehot5(req_outport_i[5*i +: 5]);
        end
        for (int o = 0; o < 5; o++) begin
            state_d[o] = state_q[o];
            owner_d[o] = owner_q[o];
            rr_d[o]    = rr_q[o];
            cnt_d[o]   = cnt_q[o];
            sel[o]     = 5'd0;
            win[o]     = 3'd0;
            found[o]   = 1'b0;
            for (int i = 0; i < 5; i++) begin
                tgt[o][i] = req_ok[i] && req_outport_i[5*i + o];
            end

            if (rst_i && downstream_on_i[o]) begin
                if (state_q[o] == S_IDLE) begin
                    for (int k = 0; k < 5; k++) begin
                        if (!found[o] && tgt[o][wrap5(4'(rr_q[o]) + 4'(k))]
                            && req_head_i[wrap5(4'(rr_q[o]) + 4'(k))]) begin
                            found[o] = 1'b1;
                            win[o]   = wrap5(4'(rr_q[o]) + 4'(k));
                        end
                    end
                    if (found[o]) sel[o][win[o]] = 1'b1;
                end else if (tgt[o][owner_q[o]] && !req_head_i[owner_q[o]]) begin
                    sel[o][owner_q[o]] = 1'b1;
                end
            end

            if (state_q[o] == S_IDLE) begin
                if (found[o]) begin
                    rr_d[o] = wrap5(4'(win[o]) + 4'd1);
                    if (!req_tail_i[win[o]]) begin
                        state_d[o] = S_LOCKED;
                        owner_d[o] = win[o];
                    end
                end
            end else if (sel[o] != 5'd0) begin
                cnt_d[o] = '0;
                if (req_tail_i[owner_q[o]]) state_d[o] = S_IDLE;
            end else if (cnt_q[o] < CW'(STALL_LIMIT)) begin
                // downstream-off cycles still count toward starvation
                cnt_d[o] = cnt_q[o] + CW'(1);
            end
            err_d[o] = err_q[o] | (cnt_d[o] == CW'(STALL_LIMIT));
        end
    end

    always_comb begin
        sa_grant_o = 5'd0;
        for (int o = 0; o < 5; o++) begin
            xbar_sel_o[5*o +: 5] = sel[o];
            outport_busy_o[o]    = (state_q[o] == S_LOCKED);
            sa_grant_o           = sa_grant_o | sel[o];
        end
    end

    assign stall_err_o = err_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int o = 0; o < 5; o++) begin
                state_q[o] <= S_IDLE;
                owner_q[o] <= 3'd0;
                rr_q[o]    <= 3'd0;
                cnt_q[o]   <= '0;
            end
            err_q <= 5'd0;
        end else begin
            for (int o = 0; o < 5; o++) begin
                state_q[o] <= state_d[o];
                owner_q[o] <= owner_d[o];
                rr_q[o]    <= rr_d[o];
                cnt_q[o]   <= cnt_d[o];
            end
            err_q <= err_d;
        end
    end

endmodule

// File: tb/tb_wormhole_switch_allocator.sv
// Bench for wormhole_switch_allocator: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural allocator model.
module tb_wormhole_switch_allocator;

    localparam int LIM = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  req_valid, req_head, req_tail, don;
    logic [24:0] req_outport;
    logic [4:0]  sa_grant, outport_busy, stall_err;
    logic [24:0] xbar_sel;

    always #5 clk = ~clk;

    wormhole_switch_allocator #(.STALL_LIMIT(LIM)) dut (
        .clk_i(clk), .rst_i(rst_n),
        .req_valid_i(req_valid), .req_outport_i(req_outport),
        .req_head_i(req_head), .req_tail_i(req_tail),
        .downstream_on_i(don),
        .sa_grant_o(sa_grant), .xbar_sel_o(xbar_sel),
        .outport_busy_o(outport_busy), .stall_err_o(stall_err)
    );

    int total = 0;
    int bad   = 0;
    bit check_en = 0;

    // model state: owner = -1 when the outport is free
    int m_owner [5];
    int m_rr    [5];
    int m_stall [5];
    bit m_err   [5];
    int m_win   [5];
    logic [4:0]  exp_g;
    logic [24:0] exp_x;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit wants(int i, int o);
        logic [4:0] f;
        f = req_outport[5*i +: 5];
        return req_valid[i] === 1'b1 && $countones(f) == 1 && f[o] === 1'b1;
    endfunction

    function automatic void model_comb();
        exp_g = '0;
        exp_x = '0;
        for (int o = 0; o < 5; o++) begin
            m_win[o] = -1;
            if (rst_n !== 1'b1 || don[o] !== 1'b1) continue;
            if (m_owner[o] < 0) begin
                for (int k = 0; k < 5; k++) begin
                    int i;
                    i = (m_rr[o] + k) % 5;
                    if (m_win[o] < 0 && wants(i, o) && req_head[i] === 1'b1) m_win[o] = i;
                end
            end else if (wants(m_owner[o], o) && req_head[m_owner[o]] === 1'b0) begin
                m_win[o] = m_owner[o];
            end
            if (m_win[o] >= 0) begin
                exp_x[5*o + m_win[o]] = 1'b1;
                exp_g[m_win[o]]       = 1'b1;
            end
        end
    endfunction

    always @(posedge clk) begin
        if (rst_n === 1'b0) begin
            for (int o = 0; o < 5; o++) begin
                m_owner[o] = -1; m_rr[o] = 0; m_stall[o] = 0; m_err[o] = 0;
            end
        end else if (rst_n === 1'b1) begin
            model_comb();
            for (int o = 0; o < 5; o++) begin
                if (m_owner[o] < 0) begin
                    if (m_win[o] >= 0) begin
                        m_rr[o] = (m_win[o] + 1) % 5;
                        if (req_tail[m_win[o]] !== 1'b1) m_owner[o] = m_win[o];
                    end
                end else if (m_win[o] >= 0) begin
                    m_stall[o] = 0;
                    if (req_tail[m_win[o]] === 1'b1) m_owner[o] = -1;
                end else begin
                    m_stall[o] = (m_stall[o] + 1 > LIM) ? LIM : m_stall[o] + 1;
                    if (m_stall[o] == LIM) m_err[o] = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            logic [4:0] eb, ee;
            model_comb();
            for (int o = 0; o < 5; o++) begin
                eb[o] = (m_owner[o] >= 0);
                ee[o] = m_err[o];
            end
            chk("m_grant", 32'(sa_grant), 32'(exp_g));
            chk("m_xbar",  32'(xbar_sel), 32'(exp_x));
            chk("m_busy",  32'(outport_busy), 32'(eb));
            chk("m_err",   32'(stall_err), 32'(ee));
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(int i, int o, bit h, bit t);
        logic [4:0] f;
        f = 5'd0;
        f[o] = 1'b1;
        req_valid[i] = 1'b1;
        req_outport[5*i +: 5] = f;
        req_head[i] = h;
        req_tail[i] = t;
    endtask

    task automatic clr_req(int i);
        req_valid[i] = 1'b0;
        req_outport[5*i +: 5] = 5'd0;
        req_head[i] = 1'b0;
        req_tail[i] = 1'b0;
    endtask

    task automatic clr_all();
        req_valid = '0; req_outport = '0; req_head = '0; req_tail = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clr_all();
        don = 5'b11111;
        next();
        check_en = 1;
        next();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        clr_all();
        don = 5'b11111;

        // single-flit packet N->E, then rr_ptr[E]=1 shows as E beating N
        do_reset();
        @(negedge clk);
        chk("rst_grant", 32'(sa_grant), 0);
        chk("rst_xbar", 32'(xbar_sel), 0);
        chk("rst_busy", 32'(outport_busy), 0);
        chk("rst_err", 32'(stall_err), 0);
        next(); set_req(0, 1, 1, 1);
        @(negedge clk);
        chk("t1_grant", 32'(sa_grant), 32'b00001);
        chk("t1_xbarE", 32'(xbar_sel[9:5]), 32'b00001);
        next(); clr_req(0);
        @(negedge clk);
        chk("t1_busy", 32'(outport_busy), 0);
        next(); set_req(0, 1, 1, 1); set_req(1, 1, 1, 1);
        @(negedge clk);
        chk("t1_rr", 32'(sa_grant), 32'b00010);
        next(); clr_all();

        // three single-flit packets to local rotate
        do_reset();
        set_req(0, 4, 1, 1); set_req(1, 4, 1, 1); set_req(2, 4, 1, 1);
        @(negedge clk); chk("t2_c0", 32'(sa_grant), 32'b00001);
        next();
        @(negedge clk); chk("t2_c1", 32'(sa_grant), 32'b00010);
        next();
        @(negedge clk); chk("t2_c2", 32'(sa_grant), 32'b00100);
        next(); clr_all();

        // W 4-flit packet to S holds off N's head
        do_reset();
        set_req(3, 2, 1, 0);
        @(negedge clk); chk("t3_c0", 32'(sa_grant), 32'b01000);
        for (int c = 1; c <= 3; c++) begin
            next();
            set_req(3, 2, 0, (c == 3));
            set_req(0, 2, 1, 0);
            @(negedge clk);
            chk("t3_wgrant", 32'(sa_grant), 32'b01000);
            chk("t3_busy", 32'(outport_busy[2]), 1);
        end
        next(); clr_req(3);
        @(negedge clk);
        chk("t3_ngrant", 32'(sa_grant), 32'b00001);
        chk("t3_unlock", 32'(outport_busy[2]), 0);
        next(); clr_all();

        // downstream off on a locked outport
        do_reset();
        set_req(3, 2, 1, 0);
        @(negedge clk); chk("t4_head", 32'(sa_grant), 32'b01000);
        next(); set_req(3, 2, 0, 0); don = 5'b11011;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t4_xbarS", 32'(xbar_sel[14:10]), 0);
            chk("t4_gW", 32'(sa_grant[3]), 0);
            next();
        end
        don = 5'b11111;
        @(negedge clk); chk("t4_resume", 32'(sa_grant[3]), 1);
        next(); set_req(3, 2, 0, 1);
        next(); clr_all();

        // stall watchdog with STALL_LIMIT=4
        do_reset();
        set_req(1, 0, 1, 0);
        @(negedge clk); chk("t5_head", 32'(sa_grant), 32'b00010);
        next(); clr_req(1);
        repeat (3) begin @(negedge clk); next(); end
        @(negedge clk); chk("t5_early", 32'(stall_err[0]), 0);
        next();
        @(negedge clk); chk("t5_err", 32'(stall_err[0]), 1);
        next(); set_req(1, 0, 0, 1);
        @(negedge clk); chk("t5_tail", 32'(sa_grant), 32'b00010);
        next(); clr_req(1);
        @(negedge clk);
        chk("t5_free", 32'(outport_busy[0]), 0);
        chk("t5_sticky", 32'(stall_err[0]), 1);

        // reset mid-packet
        do_reset();
        set_req(0, 3, 1, 0);
        @(negedge clk); chk("t6_head", 32'(sa_grant), 32'b00001);
        next(); set_req(0, 3, 0, 0);
        @(negedge clk); chk("t6_busy", 32'(outport_busy[3]), 1);
        next(); rst_n = 1'b0;
        @(negedge clk);
        chk("t6_rgrant", 32'(sa_grant), 0);
        chk("t6_rxbar", 32'(xbar_sel), 0);
        next(); rst_n = 1'b1;
        clr_req(0); set_req(1, 3, 1, 0); set_req(2, 3, 1, 0);
        @(negedge clk);
        chk("t6_busy0", 32'(outport_busy), 0);
        chk("t6_err0", 32'(stall_err), 0);
        chk("t6_rr0", 32'(sa_grant), 32'b00010);
        next(); clr_all();

        // randomized traffic, model-checked every cycle
        do_reset();
        repeat (3000) begin
            next();
            for (int i = 0; i < 5; i++) begin
                int r;
                logic [4:0] f;
                r = $urandom_range(9);
                if (r == 0)      f = 5'd0;
                else if (r == 1) f = 5'($urandom);
                else begin
                    f = 5'd0;
                    f[$urandom_range(4)] = 1'b1;
                end
                req_valid[i] = ($urandom_range(3) != 0);
                req_outport[5*i +: 5] = f;
                req_head[i] = ($urandom_range(2) == 0);
                req_tail[i] = ($urandom_range(2) == 0);
                don[i]      = ($urandom_range(5) != 0);
            end
            rst_n = ($urandom_range(199) != 0);
        end
        next();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
